// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage with a single outstanding request,
//            stall skid buffer and branch/jump redirect with response squash.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        IMemReq,
  output logic [0:31] IMemAddr,
  input  logic        IMemReady,
  input  logic [0:31] IMemData,
  input  logic [1:0]  JumpType,
  input  logic        BranchCond,
  input  logic        BranchResult,
  input  logic [0:31] DecodePCPlusFour,
  input  logic [0:25] DecodeOffset,
  input  logic [0:31] JumpRegTarget,
  output logic [0:5]  NextOpCode,
  output logic [0:5]  NextFunct,
  output logic [0:4]  NextRs1,
  output logic [0:4]  NextRs2,
  output logic [0:4]  NextRd,
  output logic [0:15] NextImmd,
  output logic [0:25] NextOffset,
  output logic [0:31] NextPCPlusFour
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetchState_t;

  localparam logic [0:5]  c_NOP_FUNCT = 6'h15;
  localparam logic [0:31] c_PC_STEP   = 32'd4;

  fetchState_t r_state, w_nextState;
  logic [0:31] r_pc, w_nextPc;
  logic        r_squash, w_nextSquash;
  logic        r_outValid, w_nextOutValid;
  logic [0:31] r_outInstr, w_nextOutInstr;
  logic [0:31] r_outPc4, w_nextOutPc4;
  logic [0:31] r_skidInstr, w_nextSkidInstr;
  logic [0:31] r_skidPc4, w_nextSkidPc4;

  logic        w_takeBranch;
  logic        w_redirect;
  logic [0:31] w_target;
  logic [0:31] w_pcPlus4;
  logic        w_showNop;

  assign w_pcPlus4    = r_pc + c_PC_STEP;
  assign w_takeBranch = (JumpType == 2'b01) && (BranchResult == BranchCond);
  assign w_redirect   = !stall && (JumpType[1] || w_takeBranch);

  always_comb begin
    case (JumpType)
      2'b01:   w_target = DecodePCPlusFour + {{16{DecodeOffset[10]}}, DecodeOffset[10:25]};
      2'b10:   w_target = DecodePCPlusFour + {{6{DecodeOffset[0]}}, DecodeOffset};
      default: w_target = JumpRegTarget;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_squash    <= 1'b0;
      r_outValid  <= 1'b0;
      r_outInstr  <= '0;
      r_outPc4    <= '0;
      r_skidInstr <= '0;
      r_skidPc4   <= '0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_squash    <= w_nextSquash;
      r_outValid  <= w_nextOutValid;
      r_outInstr  <= w_nextOutInstr;
      r_outPc4    <= w_nextOutPc4;
      r_skidInstr <= w_nextSkidInstr;
      r_skidPc4   <= w_nextSkidPc4;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextSquash    = r_squash;
    // The output stage only survives an edge while stalled
    w_nextOutValid  = stall ? r_outValid : 1'b0;
    w_nextOutInstr  = r_outInstr;
    w_nextOutPc4    = r_outPc4;
    w_nextSkidInstr = r_skidInstr;
    w_nextSkidPc4   = r_skidPc4;
    IMemReq         = 1'b0;

    if (w_redirect) begin
      w_nextPc       = w_target;
      w_nextOutValid = 1'b0;
    end

    case (r_state)
      FETCH: begin
        // No request on a redirect cycle: the sequential PC is wrong-path
        if (!stall && !w_redirect) begin
          IMemReq     = reset;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (IMemReady) begin
          w_nextSquash = 1'b0;
          if (w_redirect || r_squash) begin
            w_nextState = FETCH;
          end else if (stall) begin
            w_nextSkidInstr = IMemData;
            w_nextSkidPc4   = w_pcPlus4;
            w_nextPc        = w_pcPlus4;
            w_nextState     = HOLD;
          end else begin
            w_nextOutValid = 1'b1;
            w_nextOutInstr = IMemData;
            w_nextOutPc4   = w_pcPlus4;
            w_nextPc       = w_pcPlus4;
            w_nextState    = FETCH;
          end
        end else if (w_redirect) begin
          w_nextSquash = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          w_nextState = FETCH;
          if (!w_redirect) begin
            w_nextOutValid = 1'b1;
            w_nextOutInstr = r_skidInstr;
            w_nextOutPc4   = r_skidPc4;
          end
        end
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  assign IMemAddr  = r_pc;
  assign w_showNop = !r_outValid || w_redirect;

  assign NextOpCode     = w_showNop ? 6'h00        : r_outInstr[0:5];
  assign NextRs1        = w_showNop ? 5'h00        : r_outInstr[6:10];
  assign NextRs2        = w_showNop ? 5'h00        : r_outInstr[11:15];
  assign NextRd         = w_showNop ? 5'h00        : r_outInstr[16:20];
  assign NextFunct      = w_showNop ? c_NOP_FUNCT  : r_outInstr[26:31];
  assign NextImmd       = w_showNop ? 16'h0000     : r_outInstr[16:31];
  assign NextOffset     = w_showNop ? 26'h0000000  : r_outInstr[6:31];
  assign NextPCPlusFour = w_showNop ? 32'h00000000 : r_outPc4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit with a latency
//            programmable instruction-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        IMemReq;
  logic [0:31] IMemAddr;
  logic        IMemReady;
  logic [0:31] IMemData;
  logic [1:0]  JumpType;
  logic        BranchCond;
  logic        BranchResult;
  logic [0:31] DecodePCPlusFour;
  logic [0:25] DecodeOffset;
  logic [0:31] JumpRegTarget;
  logic [0:5]  NextOpCode;
  logic [0:5]  NextFunct;
  logic [0:4]  NextRs1;
  logic [0:4]  NextRs2;
  logic [0:4]  NextRd;
  logic [0:15] NextImmd;
  logic [0:25] NextOffset;
  logic [0:31] NextPCPlusFour;

  int          nTests = 0;
  int          nFail  = 0;
  int          memLat;
  bit          memPending;
  int          memCnt;
  logic [31:0] memAddr;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .IMemReq          (IMemReq),
    .IMemAddr         (IMemAddr),
    .IMemReady        (IMemReady),
    .IMemData         (IMemData),
    .JumpType         (JumpType),
    .BranchCond       (BranchCond),
    .BranchResult     (BranchResult),
    .DecodePCPlusFour (DecodePCPlusFour),
    .DecodeOffset     (DecodeOffset),
    .JumpRegTarget    (JumpRegTarget),
    .NextOpCode       (NextOpCode),
    .NextFunct        (NextFunct),
    .NextRs1          (NextRs1),
    .NextRs2          (NextRs2),
    .NextRd           (NextRd),
    .NextImmd         (NextImmd),
    .NextOffset       (NextOffset),
    .NextPCPlusFour   (NextPCPlusFour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h20220005;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample the request just before the edge, then drive the
  // memory response for the following cycle.
  task automatic tick();
    logic        req;
    logic [31:0] addr;
    #4;
    req  = IMemReq;
    addr = IMemAddr;
    @(posedge clk);
    #1;
    if (req) begin
      memPending = 1'b1;
      memAddr    = addr;
      memCnt     = memLat - 1;
    end
    IMemReady = 1'b0;
    IMemData  = 32'hDEADBEEF;
    if (memPending) begin
      if (memCnt == 0) begin
        IMemReady  = 1'b1;
        IMemData   = memWord(memAddr);
        memPending = 1'b0;
      end else begin
        memCnt--;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; IMemReady = 1'b0; IMemData = '0;
    JumpType = 2'b00; BranchCond = 1'b0; BranchResult = 1'b0;
    DecodePCPlusFour = '0; DecodeOffset = '0; JumpRegTarget = '0;
    memLat = 1; memPending = 1'b0; memCnt = 0; memAddr = '0;

    tick(); tick();
    checkVal("rst_req",   IMemReq, 0);
    checkVal("rst_addr",  IMemAddr, 32'h0);
    checkVal("rst_funct", NextFunct, 6'h15);
    checkVal("rst_pc4",   NextPCPlusFour, 32'h0);

    reset = 1'b1; #1;
    checkVal("first_req",  IMemReq, 1);
    checkVal("first_addr", IMemAddr, 32'h0);
    tick();
    checkVal("wait_noreq", IMemReq, 0);
    checkVal("wait_nop",   NextFunct, 6'h15);
    tick();
    checkVal("i0_op",     NextOpCode, 6'h08);
    checkVal("i0_rs1",    NextRs1, 5'd1);
    checkVal("i0_rs2",    NextRs2, 5'd2);
    checkVal("i0_rd",     NextRd, 5'd0);
    checkVal("i0_immd",   NextImmd, 16'h0005);
    checkVal("i0_funct",  NextFunct, 6'h05);
    checkVal("i0_offset", NextOffset, 26'h0220005);
    checkVal("i0_pc4",    NextPCPlusFour, 32'h4);
    checkVal("i0_next_addr", IMemAddr, 32'h4);

    // Stall in FETCH holds the output stage and suppresses requests
    stall = 1'b1;
    repeat (2) begin
      tick();
      checkVal("stall_pc4",   NextPCPlusFour, 32'h4);
      checkVal("stall_noreq", IMemReq, 0);
    end
    stall = 1'b0; #1;
    checkVal("resume_req", IMemReq, 1);
    tick();
    checkVal("cleared", NextPCPlusFour, 32'h0);

    // Response arrives under stall: skid into HOLD for three cycles
    stall = 1'b1;
    repeat (3) begin
      tick();
      checkVal("hold_noreq", IMemReq, 0);
      checkVal("hold_nop",   NextPCPlusFour, 32'h0);
    end
    checkVal("hold_addr", IMemAddr, 32'h8);
    stall = 1'b0;
    tick();
    checkVal("hold_rel_pc4",  NextPCPlusFour, 32'h8);
    checkVal("hold_rel_immd", NextImmd, 16'h0001);
    checkVal("hold_rel_req",  IMemReq, 1);
    tick();
    checkVal("hold_once", NextPCPlusFour, 32'h0);
    tick();
    checkVal("seq_pc4",  NextPCPlusFour, 32'hC);
    checkVal("seq_immd", NextImmd, 16'h000D);

    // Taken branch under stall is ignored, then taken once stall drops
    stall = 1'b1; JumpType = 2'b01; BranchCond = 1'b1; BranchResult = 1'b1;
    DecodePCPlusFour = 32'h100; DecodeOffset = 26'h000FFF8; #1;
    checkVal("stall_br_keep", NextPCPlusFour, 32'hC);
    tick();
    checkVal("stall_br_addr", IMemAddr, 32'hC);
    checkVal("stall_br_pc4",  NextPCPlusFour, 32'hC);
    stall = 1'b0; #1;
    checkVal("br_nop",   NextFunct, 6'h15);
    checkVal("br_noreq", IMemReq, 0);
    tick();
    JumpType = 2'b00; #1;
    checkVal("br_addr", IMemAddr, 32'hF8);
    checkVal("br_req",  IMemReq, 1);
    tick(); tick();
    checkVal("br_pc4", NextPCPlusFour, 32'hFC);

    // Jump register while waiting on a 3-cycle response
    memLat = 3;
    tick();
    JumpType = 2'b11; JumpRegTarget = 32'h400;
    tick();
    JumpType = 2'b00; #1;
    checkVal("jr_wait_noreq", IMemReq, 0);
    checkVal("jr_wait_addr",  IMemAddr, 32'h400);
    tick();
    checkVal("jr_still_wait", IMemReq, 0);
    tick();
    checkVal("jr_addr",    IMemAddr, 32'h400);
    checkVal("jr_req",     IMemReq, 1);
    checkVal("jr_discard", NextPCPlusFour, 32'h0);
    memLat = 1;

    // PC wrap at the top of the address space
    JumpType = 2'b11; JumpRegTarget = 32'hFFFFFFFC;
    tick();
    JumpType = 2'b00; #1;
    checkVal("wrap_fetch_addr", IMemAddr, 32'hFFFFFFFC);
    tick(); tick();
    checkVal("wrap_addr", IMemAddr, 32'h0);
    checkVal("wrap_immd", NextImmd, 16'hFFF9);
    checkVal("wrap_pc4",  NextPCPlusFour, 32'h0);

    // PC-relative jump coinciding with the response: no squash left behind
    tick();
    JumpType = 2'b10; DecodePCPlusFour = 32'h200; DecodeOffset = 26'h3FFFFF0;
    tick();
    JumpType = 2'b00; #1;
    checkVal("jmp_addr", IMemAddr, 32'h1F0);
    checkVal("jmp_nop",  NextPCPlusFour, 32'h0);
    tick(); tick();
    checkVal("jmp_pc4", NextPCPlusFour, 32'h1F4);

    // Reset in WAIT; the late response after release must be ignored
    memLat = 2;
    tick();
    reset = 1'b0; #1;
    checkVal("rst_mid_req",  IMemReq, 0);
    checkVal("rst_mid_addr", IMemAddr, 32'h0);
    checkVal("rst_mid_nop",  NextPCPlusFour, 32'h0);
    tick();
    reset = 1'b1; #1;
    checkVal("rel_req",  IMemReq, 1);
    checkVal("rel_addr", IMemAddr, 32'h0);
    tick();
    checkVal("late_ignored", NextPCPlusFour, 32'h0);
    checkVal("late_wait",    IMemReq, 0);
    tick(); tick();
    checkVal("post_rst_pc4",  NextPCPlusFour, 32'h4);
    checkVal("post_rst_immd", NextImmd, 16'h0005);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0, is the PC loaded by reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 stall  in  1  hazard stall; fetch does not advance and does not redirect.
REQ-005 IMemReq  out  1  one-cycle instruction-memory request pulse.
REQ-006 IMemAddr  out  32  [0:31] request address.
REQ-007 IMemReady  in  1  response valid, at least 1 cycle after IMemReq.
REQ-008 IMemData  in  32  [0:31] instruction word, valid with IMemReady.
REQ-009 JumpType  in  2  from decode: 00 none, 01 conditional branch, 10 PC-relative jump, 11 jump register.
REQ-010 BranchCond, BranchResult  in  1 each  branch taken when equal.
REQ-011 DecodePCPlusFour  in  32  PC+4 of the instruction in decode.
REQ-012 DecodeOffset  in  26  offset field of the instruction in decode.
REQ-013 JumpRegTarget  in  32  register target for JumpType 11.
REQ-014 NextOpCode, NextFunct  out  6 each; NextRs1, NextRs2, NextRd  out  5 each; NextImmd  out  16; NextOffset  out  26; NextPCPlusFour  out  32.

Function
REQ-015 Field split: op [0:5], rs1 [6:10], rs2 [11:15], rd [16:20], funct [26:31], immd [16:31], offset [6:31].
REQ-016 Next* outputs come from a registered output stage (valid, instruction, PC+4).
REQ-017 NOP = op 0, funct 6'h15, all other Next* fields 0, NextPCPlusFour 0.
REQ-018 Next* show NOP when the output stage is invalid or a redirect is active.
REQ-019 FSM states: FETCH, WAIT, HOLD.
REQ-020 FETCH, stall=0: IMemReq=1, IMemAddr=PC, then go to WAIT.
REQ-021 FETCH, stall=1: IMemReq=0; remain in FETCH.
REQ-022 WAIT, IMemReady=1, squash=0, stall=0: load the output stage with IMemData and PC+4, set PC to PC+4, go to FETCH.
REQ-023 WAIT, IMemReady=1, squash=0, stall=1: capture IMemData and PC+4 into a skid register, set PC to PC+4, go to HOLD.
REQ-024 HOLD: when stall falls, transfer the skid register to the output stage and go to FETCH.
REQ-025 The output stage holds while stall=1 and clears to invalid on every stall=0 edge that does not reload it.
REQ-026 redirect = !stall & (JumpType==10 | JumpType==11 | (JumpType==01 & BranchResult==BranchCond)).
REQ-027 Target for JumpType 01: DecodePCPlusFour + sign-extend(DecodeOffset[10:25]).
REQ-028 Target for JumpType 10: DecodePCPlusFour + sign-extend(DecodeOffset).
REQ-029 Target for JumpType 11: JumpRegTarget.
REQ-030 All PC arithmetic is 32-bit and wraps modulo 2^32.
REQ-031 On redirect: PC takes the target, output stage and skid are invalidated, and the FSM leaves HOLD for FETCH.
REQ-032 Redirect in WAIT with no IMemReady sets squash and stays in WAIT; the squashed response is discarded, squash clears, and the FSM goes to FETCH at the target.
REQ-033 Redirect in the same cycle as IMemReady discards the data and goes to FETCH at the target without setting squash.
REQ-034 There is at most one outstanding request, and there is no branch delay slot.
REQ-035 Latency with stall=0 and a 1-cycle memory: request at cycle n, Next* valid at n+2, one instruction per 2 cycles.

Reset
REQ-036 While reset=0: PC=RESET_PC, state=FETCH, output stage/skid/squash cleared, IMemReq=0, IMemAddr=RESET_PC, Next* = NOP.
REQ-037 Reset assertion mid-WAIT abandons the request; a late IMemReady after release while in FETCH is ignored.
REQ-038 The first IMemReq occurs on the first cycle after reset release.

Verification
REQ-039 Reset release with 1-cycle memory returning 32'h20220005 -> IMemAddr 0, then NextOpCode 6'h08, NextRs1 1, NextRs2 2, NextImmd 5, NextPCPlusFour 4.
REQ-040 Stall held 3 cycles while IMemReady arrives -> HOLD entered, Next* stable, no IMemReq, instruction appears once on release.
REQ-041 JumpType 01, BranchCond=BranchResult=1, DecodePCPlusFour 32'h100, offset low16 16'hFFF8 -> Next* NOP that cycle, next IMemAddr 32'hF8.
REQ-042 JumpType 11 in WAIT before a 3-cycle response, JumpRegTarget 32'h400 -> response discarded, next IMemAddr 32'h400.
REQ-043 PC 32'hFFFFFFFC fetched -> next IMemAddr 32'h0.
REQ-044 Redirect with stall=1 -> ignored; same JumpType with stall=0 -> taken.
